// File: rtl/sum_tx_sequencer.sv
// -----------------------------------------------------------------------------
// sum_tx_sequencer
//
// Sequences a byte-wide UART transmitter to send the ASCII message "A+B=SS"
// (optionally followed by CR LF). A and B are 4-bit operands captured on a
// start request, and SS is their 5-bit sum printed as two hex digits. Each
// byte uses a handshake on the transmitter's busy flag. One further request
// can wait in a pending slot while a message is in flight. If the
// transmitter never acknowledges a byte, the message is aborted.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   request pulse, sampled every cycle
//   op_a      in   [3:0] operand A, sampled with start
//   op_b      in   [3:0] operand B, sampled with start
//   tx_busy   in   UART TX busy flag
//   tx_start  out  one-cycle strobe launching tx_data
//   tx_data   out  [7:0] byte to send; held until the next tx_start
//   seq_busy  out  high whenever a message is in progress
//   done      out  one-cycle pulse, message fully sent
//   err       out  one-cycle pulse, acknowledge timeout abort
//   overrun   out  one-cycle pulse, start dropped (pending slot full)
// -----------------------------------------------------------------------------
module sum_tx_sequencer #(
  parameter bit          CRLF        = 1'b1,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       seq_busy,
  output logic       done,
  output logic       err,
  output logic       overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_e;

  localparam logic [2:0] LAST_IDX  = CRLF ? 3'd7 : 3'd5;
  localparam logic [7:0] TIMER_MAX = 8'(ACK_TIMEOUT - 1);

  state_e     state_q;
  logic [3:0] a_q, b_q;
  logic [4:0] sum_q;
  logic [2:0] idx_q;
  logic [7:0] timer_q;
  logic       pend_q;
  logic [3:0] pend_a_q, pend_b_q;
  logic       tx_start_q, done_q, err_q, overrun_q;
  logic [7:0] tx_data_q;
  logic [7:0] cur_byte;

  // One hex digit as uppercase ASCII.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Message byte selected by the current index.
  always_comb begin
    // NOTE: default first so every path assigns cur_byte and no latch is inferred.
    cur_byte = 8'h00;
    case (idx_q)
      3'd0:    cur_byte = hex_ascii(a_q);
      3'd1:    cur_byte = 8'h2B;
      3'd2:    cur_byte = hex_ascii(b_q);
      3'd3:    cur_byte = 8'h3D;
      3'd4:    cur_byte = hex_ascii({3'b000, sum_q[4]});
      3'd5:    cur_byte = hex_ascii(sum_q[3:0]);
      3'd6:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it takes effect only on a clock edge.
    if (reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      pend_q     <= 1'b0;
      pend_a_q   <= '0;
      pend_b_q   <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout. Where two assignments hit
      // the same register, the later one in this block wins.
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      overrun_q  <= 1'b0;

      // A start that arrives while busy goes to the pending slot, or is
      // dropped if the slot is already occupied.
      if (start && state_q != S_IDLE) begin
        if (pend_q) begin
          overrun_q <= 1'b1;
        end else begin
          pend_q   <= 1'b1;
          pend_a_q <= op_a;
          pend_b_q <= op_b;
        end
      end

      case (state_q)
        S_IDLE: begin
          // The slot can be full here if a start coincided with the done
          // transition of a message that had no pending request.
          if (pend_q) begin
            a_q       <= pend_a_q;
            b_q       <= pend_b_q;
            sum_q     <= {1'b0, pend_a_q} + {1'b0, pend_b_q};
            idx_q     <= '0;
            pend_q    <= 1'b0;
            state_q   <= S_ISSUE;
            overrun_q <= start;
          end else if (start) begin
            a_q     <= op_a;
            b_q     <= op_b;
            sum_q   <= {1'b0, op_a} + {1'b0, op_b};
            idx_q   <= '0;
            state_q <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (!tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= cur_byte;
            timer_q    <= '0;
            state_q    <= S_WAIT_ACK;
          end
        end

        S_WAIT_ACK: begin
          if (tx_busy) begin
            state_q <= S_WAIT_DONE;
          end else if (timer_q == TIMER_MAX) begin
            // The abort also discards any request that was pended meanwhile.
            err_q   <= 1'b1;
            pend_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end

        S_WAIT_DONE: begin
          if (!tx_busy) begin
            if (idx_q == LAST_IDX) begin
              done_q <= 1'b1;
              if (pend_q) begin
                // Chain straight into the pending request with no idle cycle.
                a_q     <= pend_a_q;
                b_q     <= pend_b_q;
                sum_q   <= {1'b0, pend_a_q} + {1'b0, pend_b_q};
                idx_q   <= '0;
                pend_q  <= 1'b0;
                state_q <= S_ISSUE;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= S_ISSUE;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign seq_busy = (state_q != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign overrun  = overrun_q;

endmodule
